// File: rtl/project_ram_responder2021.sv
// RAM-side responder for the projectCPU2021 memory port, with a streaming boot loader
// that fills the store from address 0 while holding the CPU in reset. Optional MEM_STATS_EN adds read/write cycle counters.
module project_ram_responder2021 #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wrEn,
   input  logic [ADDR_W-1:0] addr_toRAM,
   input  logic [DATA_W-1:0] data_toRAM,
   output logic [DATA_W-1:0] data_fromRAM,
   input  logic              ld_start,
   input  logic              ld_valid,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              ld_last,
   output logic              ld_ready,
   output logic              cpu_rst,
`ifdef MEM_STATS_EN
   output logic [15:0]       rd_count,
   output logic [15:0]       wr_count,
`endif
   output logic              ld_done,
   output logic              ld_err
);

   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   ldAddr_q, ldAddr_d;
   logic                ldDone_q, ldDone_d;
   logic                ldErr_q, ldErr_d;
   logic                cpuRst_q;
   logic                ldReady_q;
   logic [DATA_W-1:0]   rdData_q, rdData_d;
   logic                ldAccept;
   logic                cpuWrite;
   logic                enterLoad;

   logic [DATA_W-1:0]   mem [DEPTH];

   assign ldAccept  = ldReady_q && ld_valid;
   assign cpuWrite  = (state_q == RUN) && wrEn;
   assign enterLoad = (state_d == LOAD) && (state_q != LOAD);

   always_comb begin
      state_d  = state_q;
      ldAddr_d = ldAddr_q;
      ldDone_d = ldDone_q;
      ldErr_d  = ldErr_q;
      unique case (state_q)
         IDLE: begin
            if (ld_start) state_d = LOAD;
         end
         LOAD: begin
            if (ldAccept) begin
               ldAddr_d = ldAddr_q + 1'b1;
               if (ld_last) begin
                  state_d  = RUN;
                  ldDone_d = 1'b1;
               end else if (&ldAddr_q) begin
                  // Store is full and the host still had more to send: flag overflow.
                  state_d  = RUN;
                  ldErr_d  = 1'b1;
                  ldDone_d = 1'b0;
               end
            end
         end
         RUN: begin
            if (ld_start) state_d = LOAD;
         end
         default: state_d = IDLE;
      endcase
      if (enterLoad) begin
         ldAddr_d = '0;
         ldDone_d = 1'b0;
         ldErr_d  = 1'b0;
      end
   end

   // Sampled before this edge's write lands, so read-during-write returns the old word.
   always_comb begin
      rdData_d = '0;
      if (state_q == RUN) rdData_d = mem[addr_toRAM];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         ldAddr_q  <= '0;
         ldDone_q  <= 1'b0;
         ldErr_q   <= 1'b0;
         cpuRst_q  <= 1'b1;
         ldReady_q <= 1'b0;
         rdData_q  <= '0;
      end else begin
         state_q   <= state_d;
         ldAddr_q  <= ldAddr_d;
         ldDone_q  <= ldDone_d;
         ldErr_q   <= ldErr_d;
         cpuRst_q  <= (state_d != RUN);
         ldReady_q <= (state_d == LOAD);
         rdData_q  <= rdData_d;
      end
   end

   always_ff @(posedge clk) begin
      if (ldAccept) begin
         mem[ldAddr_q] <= ld_data;
      end else if (cpuWrite) begin
         mem[addr_toRAM] <= data_toRAM;
      end
   end

`ifdef MEM_STATS_EN
   logic [15:0] rdCount_q;
   logic [15:0] wrCount_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdCount_q <= '0;
         wrCount_q <= '0;
      end else if (enterLoad) begin
         rdCount_q <= '0;
         wrCount_q <= '0;
      end else if (state_q == RUN) begin
         if (wrEn) begin
            if (wrCount_q != 16'hFFFF) wrCount_q <= wrCount_q + 16'd1;
         end else begin
            if (rdCount_q != 16'hFFFF) rdCount_q <= rdCount_q + 16'd1;
         end
      end
   end

   assign rd_count = rdCount_q;
   assign wr_count = wrCount_q;
`endif

   assign data_fromRAM = rdData_q;
   assign ld_ready     = ldReady_q;
   assign cpu_rst      = cpuRst_q;
   assign ld_done      = ldDone_q;
   assign ld_err       = ldErr_q;

endmodule

// File: tb/tb_project_ram_responder2021.sv
// Directed, table-driven bench for project_ram_responder2021: loader, CPU read/write,
// overflow and reset corner cases; counter checks when MEM_STATS_EN is defined.
module tb_project_ram_responder2021;

   logic        clk;
   logic        rst;
   logic        wrEn;
   logic [12:0] addr_toRAM;
   logic [15:0] data_toRAM;
   logic [15:0] data_fromRAM;
   logic        ld_start;
   logic        ld_valid;
   logic [15:0] ld_data;
   logic        ld_last;
   logic        ld_ready;
   logic        cpu_rst;
   logic        ld_done;
   logic        ld_err;
`ifdef MEM_STATS_EN
   logic [15:0] rd_count;
   logic [15:0] wr_count;
`endif

   int checkCount = 0;
   int passCount  = 0;

   typedef struct {
      logic        we;
      logic [12:0] addr;
      logic [15:0] din;
      logic        chk;
      logic [15:0] expData;
   } vec_t;

   vec_t vecs [11];

   project_ram_responder2021 dut (
      .clk         (clk),
      .rst         (rst),
      .wrEn        (wrEn),
      .addr_toRAM  (addr_toRAM),
      .data_toRAM  (data_toRAM),
      .data_fromRAM(data_fromRAM),
      .ld_start    (ld_start),
      .ld_valid    (ld_valid),
      .ld_data     (ld_data),
      .ld_last     (ld_last),
      .ld_ready    (ld_ready),
      .cpu_rst     (cpu_rst),
`ifdef MEM_STATS_EN
      .rd_count    (rd_count),
      .wr_count    (wr_count),
`endif
      .ld_done     (ld_done),
      .ld_err      (ld_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
   endtask

   task automatic applyStimulus(input logic we, input logic [12:0] a, input logic [15:0] d);
      @(negedge clk);
      wrEn       = we;
      addr_toRAM = a;
      data_toRAM = d;
      @(posedge clk);
      #1;
   endtask

   task automatic loadWord(input logic [15:0] d, input logic last);
      @(negedge clk);
      ld_valid = 1'b1;
      ld_data  = d;
      ld_last  = last;
      @(posedge clk);
      #1;
      ld_valid = 1'b0;
      ld_last  = 1'b0;
   endtask

   task automatic pulseStart();
      @(negedge clk);
      ld_start = 1'b1;
      @(posedge clk);
      #1;
      ld_start = 1'b0;
   endtask

   initial begin
      rst        = 1'b0;
      wrEn       = 1'b0;
      addr_toRAM = '0;
      data_toRAM = '0;
      ld_start   = 1'b0;
      ld_valid   = 1'b0;
      ld_data    = '0;
      ld_last    = 1'b0;

      vecs[0]  = '{1'b0, 13'h0001, 16'h0000, 1'b1, 16'h2002};
      vecs[1]  = '{1'b0, 13'h0000, 16'h0000, 1'b1, 16'hA001};
      vecs[2]  = '{1'b0, 13'h0002, 16'h0000, 1'b1, 16'h0000};
      vecs[3]  = '{1'b1, 13'h0100, 16'h1234, 1'b0, 16'h0000};
      vecs[4]  = '{1'b1, 13'h0100, 16'hBEEF, 1'b1, 16'h1234};
      vecs[5]  = '{1'b0, 13'h0100, 16'h0000, 1'b1, 16'hBEEF};
      vecs[6]  = '{1'b1, 13'h0002, 16'h5A5A, 1'b1, 16'h0000};
      vecs[7]  = '{1'b0, 13'h0002, 16'h0000, 1'b1, 16'h5A5A};
      vecs[8]  = '{1'b1, 13'h1FFF, 16'hCAFE, 1'b0, 16'h0000};
      vecs[9]  = '{1'b0, 13'h1FFF, 16'h0000, 1'b1, 16'hCAFE};
      vecs[10] = '{1'b0, 13'h0000, 16'h0000, 1'b1, 16'hA001};

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_data",    data_fromRAM, 16'h0000);
      checkOutput("rst_ready",   16'(ld_ready), 16'h0);
      checkOutput("rst_cpu_rst", 16'(cpu_rst),  16'h1);
      checkOutput("rst_done",    16'(ld_done),  16'h0);
      checkOutput("rst_err",     16'(ld_err),   16'h0);

      // Reset asserted in the middle of a load
      @(negedge clk);
      rst = 1'b1;
      pulseStart();
      checkOutput("t1_ready_load", 16'(ld_ready), 16'h1);
      loadWord(16'h1111, 1'b0);
      loadWord(16'h2222, 1'b0);
      loadWord(16'h3333, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("t1_ready_async", 16'(ld_ready), 16'h0);
      checkOutput("t1_cpu_rst",     16'(cpu_rst),  16'h1);
      checkOutput("t1_done",        16'(ld_done),  16'h0);
      @(negedge clk);
      rst = 1'b1;

      // Normal three-word load
      pulseStart();
      checkOutput("t2_ready", 16'(ld_ready), 16'h1);
      checkOutput("t2_cpu_rst_load", 16'(cpu_rst), 16'h1);
      loadWord(16'hA001, 1'b0);
      checkOutput("t2_data_zero_in_load", data_fromRAM, 16'h0000);
      loadWord(16'h2002, 1'b0);
      loadWord(16'h0000, 1'b1);
      checkOutput("t2_done",    16'(ld_done),  16'h1);
      checkOutput("t2_err",     16'(ld_err),   16'h0);
      checkOutput("t2_cpu_rst", 16'(cpu_rst),  16'h0);
      checkOutput("t2_ready_run", 16'(ld_ready), 16'h0);

      // RUN-mode read/write table
      for (int i = 0; i < 11; i++) begin
         applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].din);
         if (vecs[i].chk) checkOutput($sformatf("vec%0d", i), data_fromRAM, vecs[i].expData);
      end

      // ld_start together with a CPU write: write lands, then LOAD
      @(negedge clk);
      wrEn       = 1'b1;
      addr_toRAM = 13'h0005;
      data_toRAM = 16'h5555;
      ld_start   = 1'b1;
      @(posedge clk);
      #1;
      wrEn     = 1'b0;
      ld_start = 1'b0;
      checkOutput("t5_enter_ready", 16'(ld_ready), 16'h1);
      checkOutput("t5_enter_done",  16'(ld_done),  16'h0);
      loadWord(16'h0A00, 1'b0);
      pulseStart();
      checkOutput("t5_start_ignored", 16'(ld_ready), 16'h1);
      loadWord(16'h0A01, 1'b0);
      loadWord(16'h0A02, 1'b1);
      checkOutput("t5_done", 16'(ld_done), 16'h1);
      applyStimulus(1'b0, 13'h0000, 16'h0000);
      checkOutput("t5_rd0", data_fromRAM, 16'h0A00);
      applyStimulus(1'b0, 13'h0001, 16'h0000);
      checkOutput("t5_rd1", data_fromRAM, 16'h0A01);
      applyStimulus(1'b0, 13'h0002, 16'h0000);
      checkOutput("t5_rd2", data_fromRAM, 16'h0A02);
      applyStimulus(1'b0, 13'h0005, 16'h0000);
      checkOutput("t5_rd5_cpu_write", data_fromRAM, 16'h5555);

      // Loader word offered in RUN must not be written (ld_addr is 3 here)
      applyStimulus(1'b1, 13'h0003, 16'h0333);
      @(negedge clk);
      wrEn       = 1'b0;
      addr_toRAM = 13'h0003;
      ld_valid   = 1'b1;
      ld_data    = 16'hFFFF;
      @(posedge clk);
      #1;
      checkOutput("t5_ready_run", 16'(ld_ready), 16'h0);
      checkOutput("t5_rd3_a", data_fromRAM, 16'h0333);
      ld_valid = 1'b0;
      applyStimulus(1'b0, 13'h0003, 16'h0000);
      checkOutput("t5_rd3_nowrite", data_fromRAM, 16'h0333);

      // Overflow: 8192 words, never ld_last
      pulseStart();
      for (int i = 0; i < 8192; i++) begin
         loadWord(16'(i) ^ 16'hC3A5, 1'b0);
         if (i == 8190) checkOutput("t4_not_early", 16'(ld_ready), 16'h1);
      end
      checkOutput("t4_err",     16'(ld_err),   16'h1);
      checkOutput("t4_done",    16'(ld_done),  16'h0);
      checkOutput("t4_cpu_rst", 16'(cpu_rst),  16'h0);
      checkOutput("t4_ready",   16'(ld_ready), 16'h0);
      applyStimulus(1'b0, 13'h1FFF, 16'h0000);
      checkOutput("t4_rd_last", data_fromRAM, 16'h1FFF ^ 16'hC3A5);
      applyStimulus(1'b0, 13'h0000, 16'h0000);
      checkOutput("t4_rd_first", data_fromRAM, 16'hC3A5);
      applyStimulus(1'b0, 13'h1234, 16'h0000);
      checkOutput("t4_rd_mid", data_fromRAM, 16'h1234 ^ 16'hC3A5);

`ifdef MEM_STATS_EN
      pulseStart();
      loadWord(16'h0F0F, 1'b1);
      applyStimulus(1'b0, 13'h0000, 16'h0000);
      applyStimulus(1'b1, 13'h0010, 16'h1111);
      applyStimulus(1'b0, 13'h0001, 16'h0000);
      applyStimulus(1'b0, 13'h0002, 16'h0000);
      applyStimulus(1'b1, 13'h0011, 16'h2222);
      applyStimulus(1'b0, 13'h0003, 16'h0000);
      applyStimulus(1'b0, 13'h0004, 16'h0000);
      checkOutput("t6_rd_count", rd_count, 16'd5);
      checkOutput("t6_wr_count", wr_count, 16'd2);
      @(negedge clk);
      wrEn     = 1'b0;
      ld_start = 1'b1;
      @(posedge clk);
      #1;
      ld_start = 1'b0;
      checkOutput("t6_rd_clear", rd_count, 16'd0);
      checkOutput("t6_wr_clear", wr_count, 16'd0);
`endif

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
